// File: rtl/oppm_receiver.sv
// OPPM pulse-stream receiver: detects a start pulse, samples each symbol period
// mid-slot, and assembles the per-frame symbols MSB-first into a word.
module oppm_receiver #(
    parameter int L          = 8,
    parameter int N          = 2,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pulse_in,
    output logic                  busy,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  error
);

    localparam int F   = WORD_WIDTH / N;
    localparam int SW  = (L > 2) ? $clog2(L) : 1;
    localparam int FW  = (F > 1) ? $clog2(F + 1) : 1;
    localparam int MID = L / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_FRAME,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  pulse_prev_q;
    logic [SW-1:0]         slot_q, slot_d;
    logic [N-1:0]          sym_q, sym_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  hit_q, hit_d;
    logic [N-1:0]          hsym_q, hsym_d;
    logic                  werr_q, werr_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [N-1:0]          sym_val;
    logic [WORD_WIDTH-1:0] asm_next;
    logic                  hit_now;
    logic [N-1:0]          hsym_now;
    logic                  werr_now;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        sym_d    = sym_q;
        frame_d  = frame_q;
        hit_d    = hit_q;
        hsym_d   = hsym_q;
        werr_d   = werr_q;
        asm_d    = asm_q;
        data_d   = data_q;
        err_d    = err_q;
        sym_val  = '0;
        asm_next = asm_q;
        hit_now  = hit_q;
        hsym_now = hsym_q;
        werr_now = werr_q;

        case (state_q)
            S_IDLE: begin
                if (pulse_in && !pulse_prev_q) begin
                    state_d = S_START;
                    slot_d  = SW'(1);
                    werr_d  = 1'b0;
                    asm_d   = '0;
                    hit_d   = 1'b0;
                end
            end
            S_START: begin
                if (slot_q == SW'(L - 1)) begin
                    state_d = S_FRAME;
                    slot_d  = '0;
                    sym_d   = '0;
                    frame_d = '0;
                    hit_d   = 1'b0;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            S_FRAME: begin
                // Sample result is folded in before the close test so L=2 works.
                if (slot_q == SW'(MID) && pulse_in) begin
                    if (!hit_q) begin
                        hit_now  = 1'b1;
                        hsym_now = sym_q;
                    end else begin
                        werr_now = 1'b1;
                    end
                end
                hit_d  = hit_now;
                hsym_d = hsym_now;
                werr_d = werr_now;
                if (slot_q == SW'(L - 1)) begin
                    slot_d = '0;
                    sym_d  = sym_q + N'(1);
                    if (sym_q == '1) begin
                        if (!hit_now) werr_d = 1'b1;
                        sym_val  = hit_now ? hsym_now : '0;
                        asm_next = (asm_q << N) | WORD_WIDTH'(sym_val);
                        asm_d    = asm_next;
                        hit_d    = 1'b0;
                        frame_d  = frame_q + FW'(1);
                        if (frame_q == FW'(F - 1)) begin
                            state_d = S_DONE;
                            data_d  = asm_next;
                            err_d   = werr_d;
                        end
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pulse_prev_q <= 1'b1;
            slot_q       <= '0;
            sym_q        <= '0;
            frame_q      <= '0;
            hit_q        <= 1'b0;
            hsym_q       <= '0;
            werr_q       <= 1'b0;
            asm_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_prev_q <= pulse_in;
            slot_q       <= slot_d;
            sym_q        <= sym_d;
            frame_q      <= frame_d;
            hit_q        <= hit_d;
            hsym_q       <= hsym_d;
            werr_q       <= werr_d;
            asm_q        <= asm_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign data_valid = (state_q == S_DONE);
    assign data_out   = data_q;
    assign error      = err_q;

endmodule

// File: doc/oppm_receiver.md
# oppm_receiver

Demodulates the OPPM pulse stream produced by the transmit slot-timing stage. It recovers fixed-width data words from the serial pulse line and sits directly downstream of that stage, on the far end of the link. It detects a start pulse, then samples each L-cycle symbol period mid-slot and picks the one hot period per frame. It assembles the resulting N-bit symbols MSB-first into a word and presents it with a one-cycle valid strobe and an error flag.

## Interface
- L, default 8: clock cycles per symbol period; must be ≥ 2.
- N, default 2: bits per symbol; a frame is 2**N symbol periods.
- WORD_WIDTH, default 8: output word width; must be a multiple of N. F = WORD_WIDTH/N frames per word.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  one clock; reset is synchronous and active-high.
- pulse_in  input  1  received pulse line, already synchronised to clk.
- busy  output  1  high from the cycle after start-edge detection through the DONE cycle.
- data_out  output  WORD_WIDTH  last received word; holds until the next word completes.
- data_valid  output  1  one-cycle strobe, high when data_out/error update.
- error  output  1  framing error on the word just delivered; holds with data_out.

## Operation
- Line format: start pulse high for one symbol period (L cycles), then F frames. Each frame has 2**N symbol periods of L cycles. In a frame, pulse_in is high for the whole period whose index (0..2**N-1) equals the symbol.
- Edge detect: pulse_prev register follows pulse_in every cycle. An edge is pulse_in=1 && pulse_prev=0. pulse_prev resets to 1, so a line already high at reset release is not an edge.
- States:
  - IDLE: on edge go to START and clear the slot counter to 1. Edges are ignored in every other state.
  - START: consume the remaining L-1 cycles of the start period, then go to FRAME with slot=0, symbol=0, frame=0.
  - FRAME: the slot counter runs 0..L-1. At slot==L/2 (integer division), pulse_in is sampled.
    - If the sample is 1 and no hit has been recorded yet this frame, record the symbol index.
    - If the sample is 1 and a hit is already recorded, keep the first index and set the word error.
    - When slot==L-1, the symbol counter increments. On symbol==2**N-1 and slot==L-1, the frame closes:
      - With no hit, the symbol is 0 and the word error is set.
      - The frame's symbol is shifted into the assembly register LSB side, with earlier frames moving toward the MSB, and the frame counter increments.
    - When frame F-1 closes, go to DONE.
  - DONE: one cycle; data_out <= assembly register, error <= word error, data_valid=1; next state IDLE.
- The word error flag and assembly register clear on entry to START.
- Counter widths: slot $clog2(L), symbol N bits (wraps naturally), frame $clog2(F+1).

## Timing
- Reset values: state IDLE, data_out=0, error=0, data_valid=0, busy=0, pulse_prev=1, all counters 0.
- Reset mid-word: abandon the word, return to IDLE next cycle, leave no valid strobe, zero data_out.
- Edge seen in cycle t0, where t0 is the first cycle pulse_in=1:
  - Frame 0 period 0 occupies cycles t0+L .. t0+2L-1.
  - Period p of frame f is sampled at cycle t0 + L + (f·2**N + p)·L + L/2.
- data_valid is high exactly in cycle t0 + L + F·(2**N)·L, the DONE cycle; busy falls the cycle after.
- The earliest next accepted edge is the cycle after DONE; an edge during DONE is ignored.
- Throughput: one word per L·(1 + F·2**N) + 1 cycles minimum.

## Test plan
- Defaults (L=8, N=2, WORD_WIDTH=8, 136-cycle word): send 0xB4 (symbols 2,3,1,0) with edge at t0 → data_valid only at t0+136, data_out=0xB4, error=0, busy high t0+1..t0+136.
- Two back-to-back words, 0x00 then 0xFF, with the second start edge at t0+137 → two strobes at t0+136 and t0+273, data_out 0x00 then 0xFF, error=0 both.
- Frame 1 has pulses in periods 1 and 3, other frames clean for 0x6C → data_out=0x5C (first hit kept), error=1.
- Frame 2 has no pulse, others encode 0xE7 → frame 2 symbol reads 0, data_out=0xE3, error=1; error cleared on the next clean word.
- Assert rst at t0+60 mid-word, then send 0x5A → no strobe for the aborted word; data_out=0 until the new strobe shows 0x5A, error=0.
- Hold pulse_in=1 through reset release for 20 cycles, then drop → no edge, busy stays 0. A subsequent low→high transition starts reception normally.
